// File: rtl/router_egress_arb.sv
// router_egress_arb: round-robin packet scheduler sharing one byte link
// among three router FIFOs, with parity check and starvation watchdog.
module router_egress_arb #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic [7:0] fifo_dout_0,
  input  logic [7:0] fifo_dout_1,
  input  logic [7:0] fifo_dout_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  input  logic       egress_ready,
  output logic       egress_valid,
  output logic [7:0] egress_data,
  output logic       egress_sop,
  output logic       egress_eop,
  output logic [2:0] grant,
  output logic       parity_err,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  typedef enum logic [1:0] {
    IDLE, HEADER, PAYLOAD, PARITY
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] grant_nxt, pick, req, empty, srst;
  logic [1:0] last_grant, gidx;
  logic [5:0] count;
  logic [7:0] parity_acc, stall_cnt;
  logic       sel_empty, accept, starved;
  logic       abort, done;

  assign empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign req = ~empty;
  assign sel_empty = |(grant & empty);
  assign egress_valid = (state != IDLE) && !sel_empty;
  assign accept = egress_valid && egress_ready;
  assign starved = (state != IDLE) && sel_empty;

  assign read_enb_0 = accept && grant[0];
  assign read_enb_1 = accept && grant[1];
  assign read_enb_2 = accept && grant[2];
  assign egress_sop = (state == HEADER) && egress_valid;
  assign egress_eop = (state == PARITY) && egress_valid;
  assign soft_reset_0 = srst[0];
  assign soft_reset_1 = srst[1];
  assign soft_reset_2 = srst[2];

  always_comb begin
    egress_data = 8'h00;
    gidx = 2'd0;
    unique case (1'b1)
      grant[0]: egress_data = fifo_dout_0;
      grant[1]: begin
        egress_data = fifo_dout_1;
        gidx = 2'd1;
      end
      grant[2]: begin
        egress_data = fifo_dout_2;
        gidx = 2'd2;
      end
      default: ;
    endcase
  end

  // search starts one past the channel served last
  always_comb begin
    pick = 3'b000;
    case (last_grant)
      2'd0: pick = req[1] ? 3'b010 :
                   req[2] ? 3'b100 :
                   req[0] ? 3'b001 : 3'b000;
      2'd1: pick = req[2] ? 3'b100 :
                   req[0] ? 3'b001 :
                   req[1] ? 3'b010 : 3'b000;
      default: pick = req[0] ? 3'b001 :
                      req[1] ? 3'b010 :
                      req[2] ? 3'b100 : 3'b000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    abort = 1'b0;
    done = 1'b0;
    if (state == IDLE) begin
      if (|pick) begin
        grant_nxt = pick;
        state_nxt = HEADER;
      end
    end else if (starved &&
                 stall_cnt == 8'(TIMEOUT - 1)) begin
      abort = 1'b1;
      state_nxt = IDLE;
      grant_nxt = 3'b000;
    end else if (accept) begin
      case (state)
        HEADER: state_nxt =
          (egress_data[7:2] == 6'd0) ? PARITY : PAYLOAD;
        PAYLOAD:
          if (count == 6'd1) state_nxt = PARITY;
        PARITY: begin
          state_nxt = IDLE;
          grant_nxt = 3'b000;
          done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      grant <= 3'b000;
      last_grant <= 2'd2;
      count <= 6'd0;
      parity_acc <= 8'h00;
      stall_cnt <= 8'd0;
      parity_err <= 1'b0;
      srst <= 3'b000;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      parity_err <= done && (egress_data != parity_acc);
      srst <= abort ? grant : 3'b000;
      if (done || abort) last_grant <= gidx;
      // backpressure with data present holds the count
      if (state == IDLE || accept || abort)
        stall_cnt <= 8'd0;
      else if (starved)
        stall_cnt <= stall_cnt + 8'd1;
      if (accept && state == HEADER) begin
        count <= egress_data[7:2];
        parity_acc <= egress_data;
      end else if (accept && state == PAYLOAD) begin
        count <= count - 6'd1;
        parity_acc <= parity_acc ^ egress_data;
      end
    end
  end

endmodule

// File: tb/tb_router_egress_arb.sv
// tb_router_egress_arb: directed and randomized checks of the egress
// scheduler against a packet-level round-robin model.
module tb_router_egress_arb;
  localparam int TO = 30;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] fe = 3'b111;
  logic [7:0] fd [3];
  logic       egress_ready = 1'b1;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       egress_valid;
  logic [7:0] egress_data;
  logic       egress_sop, egress_eop;
  logic [2:0] grant;
  logic       parity_err;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] q [3][$];
  logic [7:0] pay [$];
  logic [7:0] mdl [3][$];
  int         mlen [3][$];
  logic [7:0] exp_stream [$];
  int         exp_pch [$];
  int         exp_perr = 0;
  int         rr_last = 2;

  logic [7:0] rx_stream [$];
  logic [7:0] cur [$];
  int         cur_ch = 0;
  int         cur_sop = 0;
  int         rx_pch [$];
  int         sop_cyc [$];
  int         eop_cyc [$];
  int         perr_cnt = 0;
  int         perr_cyc = 0;
  int         last_acc = 0;
  int         n_acc = 0;
  int         srst_cyc = 0;
  int         srst_gap = 0;
  int         srst_cnt [3];
  logic [2:0] srst_grant = 3'b000;

  router_egress_arb #(.TIMEOUT(TO)) dut (
    .clock(clock),
    .resetn(resetn),
    .fifo_empty_0(fe[0]),
    .fifo_empty_1(fe[1]),
    .fifo_empty_2(fe[2]),
    .fifo_dout_0(fd[0]),
    .fifo_dout_1(fd[1]),
    .fifo_dout_2(fd[2]),
    .read_enb_0(read_enb_0),
    .read_enb_1(read_enb_1),
    .read_enb_2(read_enb_2),
    .egress_ready(egress_ready),
    .egress_valid(egress_valid),
    .egress_data(egress_data),
    .egress_sop(egress_sop),
    .egress_eop(egress_eop),
    .grant(grant),
    .parity_err(parity_err),
    .soft_reset_0(soft_reset_0),
    .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 3; i++) begin
      fe[i] = (q[i].size() == 0);
      fd[i] = fe[i] ? 8'h00 : q[i][0];
    end
  endtask

  function automatic int sop_at(input int i);
    return (i < sop_cyc.size()) ? sop_cyc[i] : -1;
  endfunction

  function automatic int eop_at(input int i);
    return (i < eop_cyc.size()) ? eop_cyc[i] : -1;
  endfunction

  // one clock: observe at negedge, then pop/flush FIFOs after the edge
  task automatic step();
    logic [2:0] pops, kills;
    logic acc;
    int gi;
    @(negedge clock);
    cyc++;
    acc = egress_valid && egress_ready;
    gi = grant[2] ? 2 : grant[1] ? 1 : 0;
    pops = {read_enb_2, read_enb_1, read_enb_0};
    kills = {soft_reset_2, soft_reset_1, soft_reset_0};
    check("read_enb", pops, acc ? grant : 3'b000);
    check("valid", egress_valid, (grant != 3'b000) && !fe[gi]);
    if (egress_valid) check("data_mux", egress_data, fd[gi]);
    if (acc) begin
      n_acc++;
      last_acc = cyc;
      if (egress_sop) begin
        cur.delete();
        cur_ch = gi;
        cur_sop = cyc;
      end
      cur.push_back(egress_data);
      if (egress_eop) begin
        foreach (cur[k]) rx_stream.push_back(cur[k]);
        rx_pch.push_back(cur_ch);
        sop_cyc.push_back(cur_sop);
        eop_cyc.push_back(cyc);
      end
    end
    if (parity_err) begin
      perr_cnt++;
      perr_cyc = cyc;
    end
    for (int i = 0; i < 3; i++) begin
      if (kills[i]) begin
        srst_cnt[i]++;
        srst_cyc = cyc;
        srst_gap = cyc - last_acc;
        srst_grant = grant;
      end
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (pops[i] && q[i].size() != 0) void'(q[i].pop_front());
      if (kills[i]) q[i].delete();
    end
    refresh();
  endtask

  task automatic clear_logs();
    rx_stream.delete();
    cur.delete();
    rx_pch.delete();
    sop_cyc.delete();
    eop_cyc.delete();
    exp_stream.delete();
    exp_pch.delete();
    perr_cnt = 0;
    exp_perr = 0;
    n_acc = 0;
    for (int i = 0; i < 3; i++) srst_cnt[i] = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      mdl[i].delete();
      mlen[i].delete();
    end
    refresh();
    step();
    step();
    rr_last = 2;
    clear_logs();
    resetn = 1'b1;
  endtask

  // queue one well-formed packet (payload taken from pay)
  task automatic load_pkt(input int ch, input int addr,
                          input bit corrupt);
    logic [7:0] h, p;
    h = {6'(pay.size()), 2'(addr)};
    p = h;
    q[ch].push_back(h);
    mdl[ch].push_back(h);
    foreach (pay[k]) begin
      q[ch].push_back(pay[k]);
      mdl[ch].push_back(pay[k]);
      p ^= pay[k];
    end
    if (corrupt) begin
      p ^= 8'h01;
      exp_perr++;
    end
    q[ch].push_back(p);
    mdl[ch].push_back(p);
    mlen[ch].push_back(pay.size() + 2);
    refresh();
  endtask

  // whole packets served round-robin from the channel after the last one
  task automatic predict();
    int c, n;
    while (mlen[0].size() + mlen[1].size() + mlen[2].size() > 0) begin
      c = 0;
      for (int k = 1; k <= 3; k++) begin
        c = (rr_last + k) % 3;
        if (mlen[c].size() != 0) break;
      end
      n = mlen[c].pop_front();
      repeat (n) exp_stream.push_back(mdl[c].pop_front());
      exp_pch.push_back(c);
      rr_last = c;
    end
  endtask

  task automatic wait_idle(input int mode, input int maxc);
    bit done_f;
    done_f = 1'b0;
    for (int n = 0; n < maxc && !done_f; n++) begin
      if (mode == 0) egress_ready = 1'b1;
      else if (mode == 1) egress_ready = (n % 2 == 0);
      else egress_ready = ($urandom_range(0, 3) != 0);
      step();
      done_f = q[0].size() == 0 && q[1].size() == 0 &&
               q[2].size() == 0 && grant == 3'b000;
    end
    egress_ready = 1'b1;
    step();
    check("idle_reached", done_f, 1);
  endtask

  function automatic bit same_stream();
    if (rx_stream.size() != exp_stream.size()) return 1'b0;
    foreach (rx_stream[k])
      if (rx_stream[k] !== exp_stream[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit same_order();
    if (rx_pch.size() != exp_pch.size()) return 1'b0;
    foreach (rx_pch[k])
      if (rx_pch[k] != exp_pch[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_log(input string tag);
    check({tag, "_len"}, rx_stream.size(), exp_stream.size());
    check({tag, "_bytes"}, same_stream(), 1);
    check({tag, "_order"}, same_order(), 1);
    check({tag, "_perr"}, perr_cnt, exp_perr);
  endtask

  int pc;
  int nload;

  initial begin
    refresh();
    repeat (3) step();
    check("rst_grant", grant, 3'b000);
    check("rst_link", {egress_valid, egress_sop, egress_eop}, 0);
    check("rst_rd", {read_enb_2, read_enb_1, read_enb_0}, 0);
    check("rst_pulse", {parity_err, soft_reset_2,
                        soft_reset_1, soft_reset_0}, 0);
    do_reset();

    // single packet on ch1
    pay = '{8'h11, 8'h22, 8'h33};
    load_pkt(1, 1, 1'b0);
    predict();
    pc = cyc;
    step();
    check("t1_grant", grant, 3'b010);
    wait_idle(0, 40);
    check_log("t1");
    check("t1_sop_lat", sop_at(0), pc + 2);
    check("t1_span", eop_at(0) - sop_at(0), 4);
    check("t1_parity", exp_stream[4], 8'h0D);

    // round robin with a second ch0 packet
    do_reset();
    pay = '{8'hA1}; load_pkt(0, 0, 1'b0);
    pay = '{8'hB2}; load_pkt(1, 1, 1'b0);
    pay = '{8'hC3}; load_pkt(2, 2, 1'b0);
    pay = '{8'hD4}; load_pkt(0, 0, 1'b0);
    predict();
    wait_idle(0, 100);
    check_log("t2");
    for (int i = 0; i < 3; i++)
      check("t2_gap", sop_at(i + 1) - eop_at(i), 2);

    // backpressure 1,0,1,0 on an L=4 packet
    clear_logs();
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_pkt(0, 0, 1'b0);
    predict();
    wait_idle(1, 100);
    check_log("t3");
    check("t3_acc", n_acc, 6);
    check("t3_span", eop_at(0) - sop_at(0), 10);
    check("t3_srst", srst_cnt[0] + srst_cnt[1] + srst_cnt[2], 0);

    // corrupt parity then a clean packet
    clear_logs();
    pay = '{8'h5A, 8'hA5}; load_pkt(1, 1, 1'b1);
    pay = '{8'h3C}; load_pkt(2, 2, 1'b0);
    predict();
    wait_idle(0, 100);
    check_log("t4");
    check("t4_perr_time", perr_cyc, eop_at(0) + 1);

    // starvation on ch2, then pending ch0 packet
    do_reset();
    q[2].push_back(8'h14);
    q[2].push_back(8'h01);
    q[2].push_back(8'h02);
    refresh();
    for (int n = 0; n < 10 && grant != 3'b100; n++) step();
    check("t5_grant2", grant, 3'b100);
    pay = '{8'h77};
    load_pkt(0, 0, 1'b0);
    predict();
    wait_idle(0, 200);
    check_log("t5");
    check("t5_srst2", srst_cnt[2], 1);
    check("t5_srst01", srst_cnt[0] + srst_cnt[1], 0);
    check("t5_srst_gap", srst_gap, TO + 1);
    check("t5_srst_grant", srst_grant, 3'b000);
    check("t5_regrant", sop_at(0), srst_cyc + 1);

    // zero-length packet
    clear_logs();
    pay.delete();
    load_pkt(1, 0, 1'b0);
    predict();
    wait_idle(0, 40);
    check_log("t6");
    check("t6_span", eop_at(0) - sop_at(0), 1);

    // reset in the middle of a payload
    clear_logs();
    pay = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    load_pkt(0, 0, 1'b0);
    for (int n = 0; n < 20 && cur.size() < 3; n++) step();
    check("t6_mid", cur.size(), 3);
    resetn = 1'b0;
    step();
    step();
    check("t6_rst_out", {grant, egress_valid, egress_sop,
                         egress_eop, read_enb_2, read_enb_1,
                         read_enb_0, parity_err, soft_reset_2,
                         soft_reset_1, soft_reset_0}, 0);
    check("t6_rst_srst", srst_cnt[0] + srst_cnt[1] + srst_cnt[2], 0);
    do_reset();

    // randomized rounds with random backpressure
    for (int r = 0; r < 20; r++) begin
      clear_logs();
      nload = 0;
      for (int ch = 0; ch < 3; ch++) begin
        repeat ($urandom_range(0, 2)) begin
          pay.delete();
          repeat ($urandom_range(0, 12))
            pay.push_back(8'($urandom));
          load_pkt(ch, $urandom_range(0, 3),
                   $urandom_range(0, 5) == 0);
          nload++;
        end
      end
      if (nload == 0) begin
        pay = '{8'($urandom)};
        load_pkt(r % 3, r % 4, 1'b0);
      end
      predict();
      wait_idle(2, 800);
      check_log("rnd");
      check("rnd_srst", srst_cnt[0] + srst_cnt[1] + srst_cnt[2], 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
